// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM-stage control and the 16-bit data memory.
// Loads forward from the youngest matching entry; the port drains entries when idle.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic                       st_word,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  input  logic                       ld_word,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_stall,
  input  logic                       drain_req,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_din,
  output logic                       mem_we_n,
  output logic                       mem_word,
  input  logic [DW-1:0]              mem_dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic             word_q [DEPTH];
  logic             word_d [DEPTH];

  logic          full;
  logic          push;
  logic          drain;
  logic          ld_own;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] idx;
  logic [DW-1:0] hit_data;
  logic          hit_word;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = !full && !drain_req;
  assign push     = st_valid && st_ready;

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (addr_q[idx] == ld_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign hit_data = data_q[hit_idx];
  assign hit_word = word_q[hit_idx];

  always_comb begin
    ld_stall = ld_valid && hit && !hit_word && ld_word;
    ld_data  = mem_dout;
    if (hit) begin
      if (ld_word && hit_word) ld_data = hit_data;
      else ld_data = {{(DW-8){1'b0}}, hit_data[7:0]};
    end
  end

  assign ld_own = ld_valid && !ld_stall;
  assign drain  = !ld_own && !empty;

  always_comb begin
    mem_we_n = 1'b1;
    mem_addr = ld_addr;
    mem_word = ld_word;
    mem_din  = data_q[head_q];
    unique case (1'b1)
      drain: begin
        mem_we_n = 1'b0;
        mem_addr = addr_q[head_q];
        mem_word = word_q[head_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(drain);
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    word_d  = word_q;
    if (drain) vld_d[head_q] = 1'b0;
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      word_d[tail_q] = st_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    word_q <= word_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic
// checked against a queue-based reference model and a shadow memory.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_word, st_ready;
  logic [15:0] st_addr, st_data;
  logic        ld_valid, ld_word, ld_stall;
  logic [15:0] ld_addr, ld_data;
  logic        drain_req;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic        mem_we_n, mem_word;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;
  bit allow_overlap = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        w;
  } ent_t;

  ent_t        q[$];
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_word(st_word), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_word(ld_word),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .drain_req(drain_req),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we_n(mem_we_n),
    .mem_word(mem_word), .mem_dout(mem_dout),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Memory: byte writes zero-extend, byte reads zero-extend.
  assign mem_dout = mem_word ? mem[mem_addr[7:0]]
                             : {8'h00, mem[mem_addr[7:0]][7:0]};

  always @(posedge clk) begin
    if (!mem_we_n)
      mem[mem_addr[7:0]] <= mem_word ? mem_din : {8'h00, mem_din[7:0]};
  end

  always @(posedge clk) begin
    if (rst && !allow_overlap) begin
      assert (!(st_valid && ld_valid)) else begin
        bad++;
        $error("FAIL protocol st_valid&ld_valid observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(output bit e_rdy, output bit e_stall,
                         output bit e_drain, output logic [15:0] e_ld);
    bit   found;
    ent_t e;
    found = 1'b0;
    e     = '{a: 16'h0, d: 16'h0, w: 1'b0};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!found && q[i].a == ld_addr) begin
        found = 1'b1;
        e     = q[i];
      end
    end
    e_rdy   = (q.size() < DEPTH) && !drain_req;
    e_stall = ld_valid && found && !e.w && ld_word;
    if (found)
      e_ld = (ld_word && e.w) ? e.d : {8'h00, e.d[7:0]};
    else
      e_ld = ld_word ? ref_mem[ld_addr[7:0]]
                     : {8'h00, ref_mem[ld_addr[7:0]][7:0]};
    e_drain = !(ld_valid && !e_stall) && (q.size() > 0);
  endtask

  task automatic check_cycle();
    bit          e_rdy, e_stall, e_drain;
    logic [15:0] e_ld;
    predict(e_rdy, e_stall, e_drain, e_ld);
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(e_rdy));
    chk("mem_we_n", 32'(mem_we_n), 32'(!e_drain));
    if (ld_valid) chk("ld_stall", 32'(ld_stall), 32'(e_stall));
    if (ld_valid && !e_stall) chk("ld_data", 32'(ld_data), 32'(e_ld));
    if (e_drain) begin
      chk("wr_addr", 32'(mem_addr), 32'(q[0].a));
      chk("wr_din", 32'(mem_din), 32'(q[0].d));
      chk("wr_word", 32'(mem_word), 32'(q[0].w));
    end else begin
      chk("rd_addr", 32'(mem_addr), 32'(ld_addr));
      chk("rd_word", 32'(mem_word), 32'(ld_word));
    end
  endtask

  task automatic tick();
    bit          e_rdy, e_stall, e_drain, do_push;
    logic [15:0] e_ld;
    ent_t        n;
    check_cycle();
    predict(e_rdy, e_stall, e_drain, e_ld);
    do_push = st_valid && e_rdy;
    n = '{a: st_addr, d: st_data, w: st_word};
    @(posedge clk);
    if (e_drain) begin
      ref_mem[q[0].a[7:0]] = q[0].w ? q[0].d : {8'h00, q[0].d[7:0]};
      void'(q.pop_front());
    end
    if (do_push) q.push_back(n);
    #1;
  endtask

  task automatic drive(input bit sv, input logic [15:0] sa,
                       input logic [15:0] sd, input bit sw,
                       input bit lv, input logic [15:0] la,
                       input bit lw, input bit dr);
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    st_word   = sw;
    ld_valid  = lv;
    ld_addr   = la;
    ld_word   = lw;
    drain_req = dr;
    #1;
  endtask

  task automatic idle();
    drive(0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    check_cycle();
    rst = 1'b1;
    #1;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 12 && q.size() > 0; k++) begin
      idle();
      tick();
    end
    chk("drained", 32'(empty), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    rst = 1'b0;
    st_valid = 0; st_addr = 0; st_data = 0; st_word = 0;
    ld_valid = 0; ld_addr = 0; ld_word = 0; drain_req = 0;
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(st_ready), 32'd1);
    chk("reset_we_n", 32'(mem_we_n), 32'd1);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill two entries behind a load, then reset with no clock edge.
    allow_overlap = 1'b1;
    drive(1, 16'h0030, 16'h1111, 1, 1, 16'h0010, 1, 0); tick();
    drive(1, 16'h0031, 16'h2222, 1, 1, 16'h0010, 1, 0); tick();
    allow_overlap = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0010, 1, 0);
    chk("t1_count2", 32'(count), 32'd2);
    mid_reset();
    chk("t1_ready", 32'(st_ready), 32'd1);
    idle(); tick();

    // Single word store drains one cycle after acceptance.
    drive(1, 16'h0004, 16'h1234, 1, 0, 16'h0, 0, 0); tick();
    idle();
    chk("t2_we_n", 32'(mem_we_n), 32'd0);
    chk("t2_addr", 32'(mem_addr), 32'h0004);
    chk("t2_din", 32'(mem_din), 32'h1234);
    chk("t2_word", 32'(mem_word), 32'd1);
    tick();
    idle();
    chk("t2_empty", 32'(empty), 32'd1);
    tick();

    // A held load blocks draining; fifth store is refused.
    allow_overlap = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 16'h0020 + 16'(k), 16'($urandom), 1, 1, 16'h0010, 1, 0);
      chk("t3_we_n_hold", 32'(mem_we_n), 32'd1);
      tick();
    end
    allow_overlap = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0010, 1, 0);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ready", 32'(st_ready), 32'd0);
    chk("t3_we_n", 32'(mem_we_n), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("t3_wr_we", 32'(mem_we_n), 32'd0);
      chk("t3_wr_addr", 32'(mem_addr), 32'h0020 + 32'(k));
      tick();
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // Youngest match wins; byte load from a word entry.
    allow_overlap = 1'b1;
    drive(1, 16'h0006, 16'hDEAD, 1, 1, 16'h0010, 1, 0); tick();
    drive(1, 16'h0006, 16'hBEEF, 1, 1, 16'h0010, 1, 0); tick();
    allow_overlap = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0006, 1, 0);
    chk("t4_word", 32'(ld_data), 32'hBEEF);
    chk("t4_stall", 32'(ld_stall), 32'd0);
    tick();
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0006, 0, 0);
    chk("t4_byte", 32'(ld_data), 32'h00EF);
    chk("t4_stall_b", 32'(ld_stall), 32'd0);
    tick();
    drain_all();

    // Partial hazard: stall until the byte store reaches memory.
    mem[8]     = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    drive(1, 16'h0008, 16'h12AB, 0, 0, 16'h0, 0, 0); tick();
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0008, 1, 0);
    chk("t5_stall", 32'(ld_stall), 32'd1);
    chk("t5_we_n", 32'(mem_we_n), 32'd0);
    tick();
    drive(0, 16'h0, 16'h0, 0, 1, 16'h0008, 1, 0);
    chk("t5_unstall", 32'(ld_stall), 32'd0);
    chk("t5_data", 32'(ld_data), 32'h00AB);
    tick();

    // drain_req blocks stores and empties the buffer.
    allow_overlap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0040 + 16'(k), 16'($urandom), k[0], 1, 16'h0010, 1, 0);
      tick();
    end
    allow_overlap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0050, 16'h5555, 1, 0, 16'h0, 0, 1);
      chk("t6_ready", 32'(st_ready), 32'd0);
      chk("t6_we_n", 32'(mem_we_n), 32'd0);
      tick();
    end
    drive(1, 16'h0050, 16'h5555, 1, 0, 16'h0, 0, 1);
    chk("t6_empty", 32'(empty), 32'd1);
    tick();

    // Reset mid-drain stops writes immediately.
    allow_overlap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0060 + 16'(k), 16'($urandom), 1, 1, 16'h0010, 1, 0);
      tick();
    end
    allow_overlap = 1'b0;
    drive(1, 16'h0050, 16'h5555, 1, 0, 16'h0, 0, 1);
    tick();
    chk("t6_mid_count", 32'(count), 32'd2);
    mid_reset();
    chk("t6_rst_we_n", 32'(mem_we_n), 32'd1);
    tick();
    idle(); tick();

    // Random traffic: legal exclusive ops first, then overlapping stress.
    for (int n = 0; n < 600; n++) begin
      bit sv, lv;
      allow_overlap = (n >= 300);
      sv = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 2) == 0);
      if (!allow_overlap && sv) lv = 1'b0;
      drive(sv, 16'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 1) == 1, lv, 16'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      if (n == 450) mid_reset();
      tick();
    end
    allow_overlap = 1'b0;
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
